// File: rtl/display7_pkg.sv
// Shared types, segment patterns and helper functions for the multiplexed 7-segment driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package display7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0011000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nibble);
        case (nibble)
            4'h0:    return SEG_0;
            4'h1:    return SEG_1;
            4'h2:    return SEG_2;
            4'h3:    return SEG_3;
            4'h4:    return SEG_4;
            4'h5:    return SEG_5;
            4'h6:    return SEG_6;
            4'h7:    return SEG_7;
            4'h8:    return SEG_8;
            4'h9:    return SEG_9;
            4'hA:    return SEG_A;
            4'hB:    return SEG_B;
            4'hC:    return SEG_C;
            4'hD:    return SEG_D;
            4'hE:    return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

    // At most 8 digits, so 10^8 still fits comfortably in 32 bits.
    function automatic logic [31:0] pow10(input int n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 32'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/display7_mux_driver_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift step per clock, DATA_W steps per start.
// o_done marks the cycle in which the final shift is applied, so o_bcd is valid the cycle after.
module bin2bcd_seq #(
    parameter int DATA_W   = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*N_DIGITS-1:0] o_bcd
);
    localparam int DIG_W = 4 * N_DIGITS;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DIG_W-1:0]  r_bcd;
    logic [DIG_W-1:0]  w_adj;
    logic [DATA_W-1:0] r_bin;
    logic [CNT_W-1:0]  r_cnt;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd <= '0;
            r_bin <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_bcd <= '0;
            r_bin <= i_bin;
            r_cnt <= CNT_W'(DATA_W);
        end else if (o_busy) begin
            {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
            r_cnt          <= r_cnt - 1'b1;
        end
    end

    assign o_busy = (r_cnt != '0);
    assign o_done = (r_cnt == CNT_W'(1));
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/display7_mux_driver.sv
// Multi-digit 7-segment driver: load/convert FSM, committed display registers, and a
// refresh-paced digit scan onto one shared active-low segment bus.
module display7_mux_driver
    import display7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int DATA_W      = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATA_W-1:0]   valor,
    input  logic                carrega,
    input  logic                modo_hex,
    input  logic                apaga_zeros,
    output logic                ocupado,
    output logic                pronto,
    output logic                overflow,
    output logic [6:0]          segmentos,
    output logic [N_DIGITS-1:0] anodos
);
    localparam int          DIG_W     = 4 * N_DIGITS;
    localparam int          IDX_W     = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int          REF_W     = $clog2(REFRESH_DIV);
    localparam logic [31:0] OVF_LIMIT = pow10(N_DIGITS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_load;
    logic                w_start;
    logic                w_commit;
    logic                w_conv_busy;
    logic                w_conv_done;
    logic [DIG_W-1:0]    w_bcd;
    logic [DIG_W-1:0]    r_hex_digits;
    logic                r_mode_hex;
    logic                r_ovf_pend;
    logic [DIG_W-1:0]    r_disp_digits;
    logic                r_disp_hex;
    logic                r_ovf;
    logic [REF_W-1:0]    r_refresh;
    logic [IDX_W-1:0]    r_idx;
    logic [N_DIGITS-1:0] w_lead_zero;
    logic [3:0]          w_nibble;
    logic [6:0]          w_pattern;

    bin2bcd_seq #(
        .DATA_W  (DATA_W),
        .N_DIGITS(N_DIGITS)
    ) u_bin2bcd (
        .clk    (clk),
        .reset  (reset),
        .i_start(w_start),
        .i_bin  (valor),
        .o_busy (w_conv_busy),
        .o_done (w_conv_done),
        .o_bcd  (w_bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Leaving CONV when the converter is idle is only a guard against a lost done.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (carrega) w_state_nxt = modo_hex ? DONE : CONV;
            CONV:    if (w_conv_done || !w_conv_busy) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_load   = (r_state == IDLE) && carrega;
        w_start  = w_load && !modo_hex;
        w_commit = (r_state == DONE);
        ocupado  = (r_state != IDLE);
        pronto   = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode_hex   <= 1'b0;
            r_ovf_pend   <= 1'b0;
            r_hex_digits <= '0;
        end else if (w_load) begin
            r_mode_hex   <= modo_hex;
            r_ovf_pend   <= !modo_hex && (32'(valor) >= OVF_LIMIT);
            r_hex_digits <= DIG_W'(valor);
        end
    end

    // Digits, mode and overflow change together so the scan never mixes two values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_digits <= '0;
            r_disp_hex    <= 1'b0;
            r_ovf         <= 1'b0;
        end else if (w_commit) begin
            r_disp_digits <= r_mode_hex ? r_hex_digits : w_bcd;
            r_disp_hex    <= r_mode_hex;
            r_ovf         <= r_ovf_pend;
        end
    end

    assign overflow = r_ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == REF_W'(REFRESH_DIV - 1)) begin
            r_refresh <= '0;
            r_idx     <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
        end else begin
            r_refresh <= r_refresh + 1'b1;
        end
    end

    // w_lead_zero[i] is set when digit i and every digit above it are zero.
    always_comb begin
        logic v_allz;
        v_allz      = 1'b1;
        w_lead_zero = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            v_allz         = v_allz && (r_disp_digits[4*i +: 4] == 4'd0);
            w_lead_zero[i] = v_allz;
        end
    end

    always_comb begin
        w_nibble  = r_disp_digits[{r_idx, 2'b00} +: 4];
        w_pattern = seg_decode(w_nibble);
        if (r_ovf) begin
            w_pattern = SEG_DASH;
        end else if (apaga_zeros && (r_idx != '0) && w_lead_zero[r_idx]) begin
            w_pattern = SEG_BLANK;
        end else if (!r_disp_hex && (w_nibble > 4'd9)) begin
            w_pattern = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            segmentos <= SEG_BLANK;
            anodos    <= '1;
        end else begin
            segmentos <= w_pattern;
            anodos    <= ~(N_DIGITS'(1) << r_idx);
        end
    end

endmodule

// File: tb/tb_display7_mux_driver.sv
// Bench for display7_mux_driver: directed vector table, multi-cycle corner sequences and
// randomized loads checked against an arithmetic digit model.
`timescale 1ns/1ps
module tb_display7_mux_driver;
    localparam int ND = 4;
    localparam int DW = 14;
    localparam int RD = 4;

    localparam logic [6:0] P0 = 7'b1000000, P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000;
    localparam logic [6:0] P4 = 7'b0011001, P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000;
    localparam logic [6:0] P8 = 7'b0000000, P9 = 7'b0011000, PA = 7'b0001000, PB = 7'b0000011;
    localparam logic [6:0] PC = 7'b1000110, PD = 7'b0100001, PE = 7'b0000110, PF = 7'b0001110;
    localparam logic [6:0] PBL = 7'b1111111, PDS = 7'b0111111;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] valor;
    logic          carrega;
    logic          modo_hex;
    logic          apaga_zeros;
    logic          ocupado;
    logic          pronto;
    logic          overflow;
    logic [6:0]    segmentos;
    logic [ND-1:0] anodos;

    int checks = 0;
    int failures = 0;

    display7_mux_driver #(
        .N_DIGITS   (ND),
        .DATA_W     (DW),
        .REFRESH_DIV(RD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .valor      (valor),
        .carrega    (carrega),
        .modo_hex   (modo_hex),
        .apaga_zeros(apaga_zeros),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .overflow   (overflow),
        .segmentos  (segmentos),
        .anodos     (anodos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0]   v;
        bit              hex;
        bit              ap;
        bit              ovf;
        logic [3:0][6:0] seg;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return P0;   1: return P1;   2: return P2;   3: return P3;
            4: return P4;   5: return P5;   6: return P6;   7: return P7;
            8: return P8;   9: return P9;   10: return PA;  11: return PB;
            12: return PC;  13: return PD;  14: return PE;  default: return PF;
        endcase
    endfunction

    // Reference: digit i of v in the chosen base, blanked when v < base^i, dashes on overflow.
    function automatic logic [3:0][6:0] model(input int v, input bit hex, input bit ap);
        logic [3:0][6:0] r;
        int base;
        int p;
        bit ovf;
        base = hex ? 16 : 10;
        p    = 1;
        ovf  = !hex && (v >= 10000);
        for (int i = 0; i < ND; i++) begin
            if (ovf)                       r[i] = PDS;
            else if (ap && i > 0 && v < p) r[i] = PBL;
            else                           r[i] = pat((v / p) % base);
            p = p * base;
        end
        return r;
    endfunction

    // Caller is at a negedge with the FSM idle.
    task automatic do_load(input string name, input logic [DW-1:0] v, input bit hex,
                           input int exp_lat, input bit exp_ovf);
        int lat;
        bit busy_ok;
        bit seen;
        lat = 0; busy_ok = 1'b1; seen = 1'b0;
        valor = v; modo_hex = hex; carrega = 1'b1;
        for (int c = 1; c <= 60 && !seen; c++) begin
            @(negedge clk);
            carrega = 1'b0;
            if (ocupado !== 1'b1) busy_ok = 1'b0;
            if (pronto === 1'b1) begin
                seen = 1'b1;
                lat  = c;
            end
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_ocupado"}, busy_ok, 1);
        @(negedge clk);
        check({name, "_pronto_pulse"}, pronto, 0);
        check({name, "_overflow"}, overflow, exp_ovf);
    endtask

    // Aligns to the start of a digit-0 slot and checks one full scan period.
    task automatic check_scan(input string name, input logic [3:0][6:0] exp);
        logic [ND-1:0] prev;
        logic [ND-1:0] exp_an;
        bit found;
        prev = anodos; found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (anodos == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = anodos;
        end
        check({name, "_sync"}, found, 1);
        if (found) begin
            for (int j = 0; j < ND * RD; j++) begin
                if (j > 0) @(negedge clk);
                exp_an = ~(4'b0001 << (j / RD));
                check($sformatf("%s_cyc%0d", name, j), {anodos, segmentos}, {exp_an, exp[j / RD]});
            end
        end
    endtask

    int pulses;
    int first_lat;
    bit busy_seen;
    int rv;
    bit rhex;
    bit rap;

    initial begin
        reset = 1'b1; carrega = 1'b0; valor = '0; modo_hex = 1'b0; apaga_zeros = 1'b0;

        vecs[0]  = '{14'd1234,  1'b0, 1'b0, 1'b0, {P1, P2, P3, P4}};
        vecs[1]  = '{14'h02AF,  1'b1, 1'b1, 1'b0, {PBL, P2, PA, PF}};
        vecs[2]  = '{14'd12000, 1'b0, 1'b0, 1'b1, {PDS, PDS, PDS, PDS}};
        vecs[3]  = '{14'd7,     1'b0, 1'b0, 1'b0, {P0, P0, P0, P7}};
        vecs[4]  = '{14'd7,     1'b0, 1'b1, 1'b0, {PBL, PBL, PBL, P7}};
        vecs[5]  = '{14'd0,     1'b0, 1'b1, 1'b0, {PBL, PBL, PBL, P0}};
        vecs[6]  = '{14'd9999,  1'b0, 1'b1, 1'b0, {P9, P9, P9, P9}};
        vecs[7]  = '{14'd10000, 1'b0, 1'b1, 1'b1, {PDS, PDS, PDS, PDS}};
        vecs[8]  = '{14'h3FFF,  1'b1, 1'b0, 1'b0, {P3, PF, PF, PF}};
        vecs[9]  = '{14'h0000,  1'b1, 1'b0, 1'b0, {P0, P0, P0, P0}};
        vecs[10] = '{14'h0100,  1'b1, 1'b1, 1'b0, {PBL, P1, P0, P0}};

        repeat (3) @(negedge clk);
        check("rst_segmentos", segmentos, 7'h7F);
        check("rst_anodos", anodos, 4'hF);
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        check_scan("post_reset", {P0, P0, P0, P0});

        for (int i = 0; i < 11; i++) begin
            apaga_zeros = vecs[i].ap;
            do_load($sformatf("vec%0d", i), vecs[i].v, vecs[i].hex, vecs[i].hex ? 1 : DW + 1, vecs[i].ovf);
            check_scan($sformatf("vec%0d", i), vecs[i].seg);
        end

        // A second carrega mid-conversion must be dropped without queueing.
        apaga_zeros = 1'b0;
        pulses = 0; first_lat = 0;
        valor = 14'd1234; modo_hex = 1'b0; carrega = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            carrega = (c == 3);
            if (c == 3) valor = 14'd9999;
            if (pronto === 1'b1) begin
                pulses++;
                if (first_lat == 0) first_lat = c;
            end
        end
        check("ignore_pulses", pulses, 1);
        check("ignore_latency", first_lat, DW + 1);
        check_scan("ignore_disp", {P1, P2, P3, P4});

        for (int n = 0; n < 25; n++) begin
            rv   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9990, 10010)) : int'($urandom_range(0, 16383));
            rhex = 1'($urandom_range(0, 1));
            rap  = 1'($urandom_range(0, 1));
            apaga_zeros = rap;
            do_load($sformatf("rnd%0d", n), DW'(rv), rhex, rhex ? 1 : DW + 1, !rhex && rv >= 10000);
            check_scan($sformatf("rnd%0d", n), model(rv, rhex, rap));
            apaga_zeros = !rap;
            check_scan($sformatf("rnd%0d_live", n), model(rv, rhex, !rap));
        end

        // Reset in the middle of a conversion: immediate reset outputs, no pronto afterwards.
        apaga_zeros = 1'b0;
        valor = 14'd1234; modo_hex = 1'b0; carrega = 1'b1;
        @(negedge clk);
        carrega = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_segmentos", segmentos, 7'h7F);
        check("midrst_anodos", anodos, 4'hF);
        check("midrst_ocupado", ocupado, 0);
        check("midrst_pronto", pronto, 0);
        check("midrst_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0; busy_seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (pronto === 1'b1) pulses++;
            if (ocupado === 1'b1) busy_seen = 1'b1;
        end
        check("midrst_no_pronto", pulses, 0);
        check("midrst_no_ocupado", busy_seen, 0);
        check_scan("midrst_disp", {P0, P0, P0, P0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display7_mux_driver.md
Name: display7_mux_driver

Overview:
- Parametrised multi-digit 7-segment driver; successor to the single-digit combinational BCD decoder.
- Accepts a binary value through a load strobe and converts it to digits: sequential double-dabble in decimal mode, direct nibble split in hex mode.
- Time-multiplexes the digits onto one shared active-low segment bus with active-low digit enables.
- Adds leading-zero blanking and overflow indication; sits between the processor's output register and the board display pins.

Parameters:
- N_DIGITS, 4, number of display digits (1..8).
- DATA_W, 14, width of the binary input; must be ≤ 4*N_DIGITS.
- REFRESH_DIV, 50000, clock cycles each digit stays lit; must be ≥ 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- valor  in  DATA_W  binary value to display, sampled on load.
- carrega  in  1  load strobe, one cycle; ignored while ocupado=1.
- modo_hex  in  1  sampled with carrega; 1 = hex digits, 0 = decimal.
- apaga_zeros  in  1  live control; 1 = blank leading zeros.
- ocupado  out  1  conversion in progress.
- pronto  out  1  one-cycle pulse when new digits are committed.
- overflow  out  1  last committed value does not fit in N_DIGITS.
- segmentos  out  7  bit6=g … bit0=a, active-low.
- anodos  out  N_DIGITS  one-hot-low digit enable.

Behaviour:
- Reset values (asynchronous): segmentos=7'b1111111, anodos=all 1, ocupado=0, pronto=0, overflow=0, digit registers=0, scan index=0, refresh counter=0.
- States are IDLE, CONV and DONE.
- IDLE, carrega=1: capture valor and modo_hex, then:
  - Compute overflow: decimal when valor ≥ 10^N_DIGITS; hex never.
  - Next state is CONV in decimal mode, DONE in hex mode.
- IDLE, carrega=0: remain in IDLE.
- CONV (decimal only):
  - Runs exactly DATA_W cycles.
  - Each cycle, every BCD nibble ≥ 5 gets +3, then the combined {bcd, bin} register shifts left by 1.
  - ocupado=1 throughout; exits to DONE after the DATA_W-th shift.
- DONE (one cycle): commit digits and overflow to the display registers atomically, pulse pronto=1, return to IDLE.
- Latency from carrega to pronto: DATA_W+1 cycles in decimal mode, 1 cycle in hex mode. ocupado is high in every cycle from the one after carrega until pronto, inclusive.
- carrega during CONV or DONE: ignored, with no queueing.
- Reset mid-conversion: abort, return to IDLE, clear the display registers; pronto is not emitted.
- Scan counter:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index increments modulo N_DIGITS (N_DIGITS-1 → 0).
- Outputs are registered, one cycle behind the scan index: anodos = ~(1 << idx), segmentos = pattern of digit[idx].
- Digit encoding (active-low):
  - 0..9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000.
  - A..F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - Blank: 1111111. Dash: 0111111.
- Overflow=1: every digit shows dash; blanking does not apply.
- Blanking: with apaga_zeros=1, digit i (i>0) is blank when digits i..N_DIGITS-1 are all zero. Digit 0 is never blanked, so value 0 shows a single "0".
- Decimal nibble values 10..15 cannot occur and decode to blank.
- The display keeps showing the previous committed value during CONV.

Decomposition:
- Package display7_pkg holds:
  - Segment constants: SEG_0..SEG_F, SEG_BLANK, SEG_DASH.
  - Function seg_decode(nibble) returning 7 bits.
  - Function pow10(n) used for the overflow limit.
  - State enum IDLE/CONV/DONE.
- Sub-module bin2bcd_seq (parameters DATA_W, N_DIGITS): owns the CONV datapath with start/busy/done. The top level owns the FSM glue, display registers, scan counter and decode.

Test Plan:
- Decimal 1234, N_DIGITS=4, REFRESH_DIV=4, apaga_zeros=0, pulse carrega → pronto exactly 15 cycles later; scan shows 0011001 (4) on anodos=1110, 0110000 (3) on 1101, 0100100 (2) on 1011, 1111001 (1) on 0111, each for 4 cycles.
- Hex 0x2AF, modo_hex=1, apaga_zeros=1 → pronto 1 cycle after carrega; digits read F, A, 2, blank; digit 3 segmentos=1111111.
- Decimal 12000 (≥10^4) → overflow=1 and all four digits 0111111; then load 7 → overflow=0, display 0,0,0,7 with apaga_zeros=0; with apaga_zeros=1 → blank,blank,blank,7.
- Value 0 with apaga_zeros=1 → digit 0 shows 1000000, digits 1..3 blank.
- carrega pulsed at cycle 3 of a conversion of 1234 with valor=9999 → ignored; 1234 is committed, only one pronto pulse.
- reset asserted mid-CONV → outputs immediately at reset values; after release, display shows 0000 and no pronto occurs until the next carrega.
